lsu_store_buffer: RTL and testbench

Load/store front-end between the pipeline MEM stage and the byte-addressed data memory (4 KiB, synchronous: writes and registered read data both update on the rising clock edge; MemWrite wins over MemRead). Posts stores into a small in-order FIFO that drains one store per cycle. Serialises loads behind pending stores. Checks access alignment and funct3 legality. Returns load data over a valid-only response port.

---
 rtl/lsu_pkg.sv | 50 +++++
 rtl/sync_fifo.sv | 71 +++++++
 rtl/lsu_store_buffer.sv | 191 +++++++++++++++++++
 tb/tb_lsu_store_buffer.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types and constants for the load/store front-end.
//   - RV32 load/store funct3 encodings
//   - FSM state enum for the load path
//   - packed store-buffer entry {addr, data, funct3}
//   - req_fault(): legality + alignment check for a request
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        LD_ISSUE = 2'd1,
        LD_RESP  = 2'd2
    } lsu_state_e;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [2:0]  funct3;
    } sb_entry_t;

    localparam int SB_ENTRY_W = $bits(sb_entry_t);

    // 1 when the request must be rejected: funct3 not legal for the access
    // direction, or the address is not naturally aligned for the size.
    function automatic logic req_fault(input logic        we,
                                       input logic [31:0] addr,
                                       input logic [2:0]  funct3);
        logic legal;
        logic misaligned;
        if (we) begin
            legal = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W);
        end else begin
            legal = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W) ||
                    (funct3 == F3_BU) || (funct3 == F3_HU);
        end
        // Size lives in funct3[1:0] for both signed and unsigned variants.
        case (funct3[1:0])
            2'b01:   misaligned = addr[0];
            2'b10:   misaligned = (addr[1:0] != 2'b00);
            default: misaligned = 1'b0;
        endcase
        return !legal || misaligned;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with first-word-fall-through head output.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   push, push_data write one entry (ignored when full)
//   pop             remove head entry (ignored when empty)
//   head_data       current head entry, valid while !empty
//   full, empty     status flags
//   count           number of stored entries (0..DEPTH)
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;

    logic w_push_ok;
    logic w_pop_ok;

    assign full      = (r_count == (AW+1)'(DEPTH));
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign w_push_ok = push && !full;
    assign w_pop_ok  = pop && !empty;

    // The head must be visible in the same cycle it is drained, so the
    // storage is read combinationally (small, distributed).
    assign head_data = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset; validity is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/lsu_store_buffer.sv
// lsu_store_buffer: MEM-stage load/store front-end for a synchronous
// byte-addressed data memory.
//   - stores are posted into an in-order FIFO and drained one per cycle
//     while the load FSM is idle
//   - loads wait for an empty FIFO, then take LD_ISSUE -> LD_RESP
//   - illegal funct3 / misaligned requests are consumed and reported on
//     err_valid/err_addr, never reaching the memory
// Ports:
//   req_*     request channel (valid/ready)
//   resp_*    load response (valid only, no backpressure)
//   err_*     fault report (pulse + sticky address)
//   sb_count  stores currently buffered
//   mem_*     memory port; all zero when idle
module lsu_store_buffer
    import lsu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_we,
    input  logic [31:0]               req_addr,
    input  logic [31:0]               req_wdata,
    input  logic [2:0]                req_funct3,
    output logic                      resp_valid,
    output logic [31:0]               resp_rdata,
    output logic                      err_valid,
    output logic [31:0]               err_addr,
    output logic [$clog2(DEPTH):0]    sb_count,
    output logic [31:0]               mem_addr,
    output logic                      mem_MemWrite,
    output logic                      mem_MemRead,
    output logic [31:0]               mem_WriteData,
    output logic [2:0]                mem_funct3,
    input  logic [31:0]               mem_ReadData
);

    localparam int CW = $clog2(DEPTH) + 1;

    lsu_state_e r_state;
    lsu_state_e w_state_next;

    logic [31:0] r_ld_addr;
    logic [2:0]  r_ld_funct3;
    logic        r_err_valid;
    logic [31:0] r_err_addr;

    logic                  w_fault;
    logic                  w_ready_load;
    logic                  w_accept;
    logic                  w_push;
    logic                  w_ld_start;
    logic                  w_drain;
    logic                  w_fifo_full;
    logic                  w_fifo_empty;
    logic [CW-1:0]         w_count;
    logic [SB_ENTRY_W-1:0] w_head_bits;
    sb_entry_t             w_head;
    sb_entry_t             w_push_entry;

    // ------------------------------------------------------------------
    // Request acceptance
    // ------------------------------------------------------------------
    assign w_fault = req_fault(req_we, req_addr, req_funct3);

    // With a single request port a load and a store push can never share a
    // cycle, so "no push this cycle" is already implied for loads.
    assign w_ready_load = (r_state == IDLE) && w_fifo_empty;

    // Ready is held low in the reset cycle so nothing is consumed that the
    // reset is about to discard.
    assign req_ready  = !rst && (req_we ? !w_fifo_full : w_ready_load);
    assign w_accept   = req_valid && req_ready;
    assign w_push     = w_accept && req_we && !w_fault;
    assign w_ld_start = w_accept && !req_we && !w_fault;

    // Drain only while the load path is idle, never during reset.
    assign w_drain = !rst && (r_state == IDLE) && !w_fifo_empty;

    assign w_push_entry = '{addr: req_addr, data: req_wdata, funct3: req_funct3};
    assign w_head       = w_head_bits;

    sync_fifo #(
        .WIDTH (SB_ENTRY_W),
        .DEPTH (DEPTH)
    ) u_store_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (w_push),
        .push_data (w_push_entry),
        .pop       (w_drain),
        .head_data (w_head_bits),
        .full      (w_fifo_full),
        .empty     (w_fifo_empty),
        .count     (w_count)
    );

    assign sb_count = w_count;

    // ------------------------------------------------------------------
    // Load FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        mem_addr      = 32'd0;
        mem_MemWrite  = 1'b0;
        mem_MemRead   = 1'b0;
        mem_WriteData = 32'd0;
        mem_funct3    = 3'd0;
        resp_valid    = 1'b0;
        resp_rdata    = 32'd0;

        case (r_state)
            IDLE: begin
                if (w_ld_start) begin
                    w_state_next = LD_ISSUE;
                end
                if (w_drain) begin
                    mem_addr      = w_head.addr;
                    mem_MemWrite  = 1'b1;
                    mem_WriteData = w_head.data;
                    mem_funct3    = w_head.funct3;
                end
            end
            LD_ISSUE: begin
                w_state_next = LD_RESP;
                mem_addr     = r_ld_addr;
                mem_MemRead  = 1'b1;
                mem_funct3   = r_ld_funct3;
            end
            LD_RESP: begin
                w_state_next = IDLE;
                resp_valid   = 1'b1;
                resp_rdata   = mem_ReadData;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase

        // A reset cycle must not touch memory or deliver a dropped load.
        if (rst) begin
            mem_addr      = 32'd0;
            mem_MemWrite  = 1'b0;
            mem_MemRead   = 1'b0;
            mem_WriteData = 32'd0;
            mem_funct3    = 3'd0;
            resp_valid    = 1'b0;
            resp_rdata    = 32'd0;
        end
    end

    // ------------------------------------------------------------------
    // Load request capture and fault reporting
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ld_addr   <= 32'd0;
            r_ld_funct3 <= 3'd0;
        end else if (w_ld_start) begin
            r_ld_addr   <= req_addr;
            r_ld_funct3 <= req_funct3;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err_valid <= 1'b0;
            r_err_addr  <= 32'd0;
        end else begin
            r_err_valid <= w_accept && w_fault;
            if (w_accept && w_fault) begin
                r_err_addr <= req_addr;
            end
        end
    end

    assign err_valid = r_err_valid;
    assign err_addr  = r_err_addr;

endmodule

// File: tb/tb_lsu_store_buffer.sv
// Testbench for lsu_store_buffer: directed scenarios followed by random
// traffic, checked every cycle against a transaction-level reference model
// (program-order byte image, expected store queue, load phase counter).
module tb_lsu_store_buffer;
    import lsu_pkg::*;

    localparam int DEPTH = 2;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [31:0]   req_addr;
    logic [31:0]   req_wdata;
    logic [2:0]    req_funct3;
    logic          resp_valid;
    logic [31:0]   resp_rdata;
    logic          err_valid;
    logic [31:0]   err_addr;
    logic [CW-1:0] sb_count;
    logic [31:0]   mem_addr;
    logic          mem_MemWrite;
    logic          mem_MemRead;
    logic [31:0]   mem_WriteData;
    logic [2:0]    mem_funct3;
    logic [31:0]   mem_ReadData;

    always #5 clk = ~clk;

    lsu_store_buffer #(.DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_we        (req_we),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .req_funct3    (req_funct3),
        .resp_valid    (resp_valid),
        .resp_rdata    (resp_rdata),
        .err_valid     (err_valid),
        .err_addr      (err_addr),
        .sb_count      (sb_count),
        .mem_addr      (mem_addr),
        .mem_MemWrite  (mem_MemWrite),
        .mem_MemRead   (mem_MemRead),
        .mem_WriteData (mem_WriteData),
        .mem_funct3    (mem_funct3),
        .mem_ReadData  (mem_ReadData)
    );

    // ---------------- data memory (environment) ----------------
    logic [7:0]  mem_bytes [4096];
    logic [31:0] rd_reg;
    assign mem_ReadData = rd_reg;

    function automatic logic [31:0] load_ext(input logic [7:0] b0, b1, b2, b3,
                                             input logic [2:0] f3);
        case (f3)
            F3_B:    return {{24{b0[7]}}, b0};
            F3_H:    return {{16{b1[7]}}, b1, b0};
            F3_W:    return {b3, b2, b1, b0};
            F3_BU:   return {24'd0, b0};
            F3_HU:   return {16'd0, b1, b0};
            default: return 32'd0;
        endcase
    endfunction

    always @(posedge clk) begin
        if (mem_MemWrite) begin
            mem_bytes[mem_addr[11:0]] <= mem_WriteData[7:0];
            if (mem_funct3 == F3_H || mem_funct3 == F3_W)
                mem_bytes[mem_addr[11:0] + 12'd1] <= mem_WriteData[15:8];
            if (mem_funct3 == F3_W) begin
                mem_bytes[mem_addr[11:0] + 12'd2] <= mem_WriteData[23:16];
                mem_bytes[mem_addr[11:0] + 12'd3] <= mem_WriteData[31:24];
            end
        end else if (mem_MemRead) begin
            rd_reg <= load_ext(mem_bytes[mem_addr[11:0]], mem_bytes[mem_addr[11:0] + 12'd1],
                               mem_bytes[mem_addr[11:0] + 12'd2], mem_bytes[mem_addr[11:0] + 12'd3],
                               mem_funct3);
        end
    end

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
        logic [2:0]  f;
    } st_t;

    logic [7:0]  ref_mem [4096];
    st_t         q[$];
    int          phase;        // 0 idle, 1 read issued, 2 response due
    logic [31:0] ld_addr;
    logic [2:0]  ld_f3;
    logic [31:0] ld_exp;
    logic        err_pend;
    logic [31:0] err_a;

    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    logic        last_acc;
    int          acc_cyc, resp_cyc, resp_total;
    logic [31:0] resp_data;
    int          stall_total;

    function automatic logic tb_fault(input logic we, input logic [31:0] a, input logic [2:0] f);
        logic ok;
        if (we) ok = (f inside {3'b000, 3'b001, 3'b010});
        else    ok = (f inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
        if (!ok) return 1'b1;
        if (f[1:0] == 2'b01 && a[0]) return 1'b1;
        if (f[1:0] == 2'b10 && a[1:0] != 2'b00) return 1'b1;
        return 1'b0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic ref_store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f);
        int n;
        n = (f == F3_W) ? 4 : (f == F3_H) ? 2 : 1;
        for (int i = 0; i < n; i++) ref_mem[12'(a[11:0] + 12'(i))] = d[8*i +: 8];
    endtask

    // One clock: compare outputs against the model, then advance the model
    // across the edge.
    task automatic tick();
        logic exp_ready, f;
        logic [11:0] a;
        #1;
        chk("sb_count", 32'(sb_count), 32'(q.size()));
        chk("err_valid", 32'(err_valid), 32'(err_pend));
        chk("err_addr", err_addr, err_a);
        chk("resp_valid", 32'(resp_valid), 32'(phase == 2));
        if (phase == 2) chk("resp_rdata", resp_rdata, ld_exp);
        if (phase == 1) begin
            chk("rd_MemRead", 32'(mem_MemRead), 1);
            chk("rd_MemWrite", 32'(mem_MemWrite), 0);
            chk("rd_addr", mem_addr, ld_addr);
            chk("rd_funct3", 32'(mem_funct3), 32'(ld_f3));
        end else if (phase == 0 && q.size() > 0) begin
            chk("wr_MemWrite", 32'(mem_MemWrite), 1);
            chk("wr_MemRead", 32'(mem_MemRead), 0);
            chk("wr_addr", mem_addr, q[0].a);
            chk("wr_data", mem_WriteData, q[0].d);
            chk("wr_funct3", 32'(mem_funct3), 32'(q[0].f));
        end else begin
            chk("mem_idle", 32'(|{mem_MemWrite, mem_MemRead, mem_addr, mem_WriteData, mem_funct3}), 0);
        end
        exp_ready = req_we ? (q.size() < DEPTH) : (phase == 0 && q.size() == 0);
        chk("req_ready", 32'(req_ready), 32'(exp_ready));

        if (resp_valid === 1'b1) begin
            resp_cyc  = cyc;
            resp_data = resp_rdata;
            resp_total++;
        end

        last_acc = req_valid && exp_ready;
        f = tb_fault(req_we, req_addr, req_funct3);
        if (last_acc) acc_cyc = cyc;
        if (phase == 0 && q.size() > 0) void'(q.pop_front());
        if (phase == 1)      phase = 2;
        else if (phase == 2) phase = 0;
        err_pend = last_acc && f;
        if (last_acc && f) err_a = req_addr;
        if (last_acc && !f) begin
            if (req_we) begin
                q.push_back('{a: req_addr, d: req_wdata, f: req_funct3});
                ref_store(req_addr, req_wdata, req_funct3);
            end else begin
                phase   = 1;
                ld_addr = req_addr;
                ld_f3   = req_funct3;
                a       = req_addr[11:0];
                ld_exp  = load_ext(ref_mem[a], ref_mem[a + 12'd1], ref_mem[a + 12'd2],
                                   ref_mem[a + 12'd3], req_funct3);
            end
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic idle(input int n);
        req_valid = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    // Present a request and hold it until accepted (bounded).
    task automatic req(input logic we, input logic [31:0] a, input logic [31:0] d,
                       input logic [2:0] f);
        int n;
        n = 0;
        req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d; req_funct3 = f;
        tick();
        while (!last_acc && n < 50) begin
            n++;
            tick();
        end
        if (!last_acc) chk("req_timeout", 0, 1);
        stall_total += n;
        req_valid = 1'b0;
        $display("req we=%0d addr=%h data=%h f3=%0d accepted cycle %0d after %0d stalls",
                 we, a, d, f, acc_cyc, n);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid = 1'b0;
        #1;
        chk("rst_cycle_mem_idle", 32'(|{mem_MemWrite, mem_MemRead, mem_addr, mem_WriteData, mem_funct3}), 0);
        chk("rst_cycle_resp_valid", 32'(resp_valid), 0);
        @(posedge clk);
        @(negedge clk);
        cyc++;
        rst = 1'b0;
        q.delete();
        phase    = 0;
        err_pend = 1'b0;
        err_a    = 32'd0;
        for (int i = 0; i < 4096; i++) ref_mem[i] = mem_bytes[i];
        #1;
        chk("post_rst_sb_count", 32'(sb_count), 0);
        chk("post_rst_resp_rdata", resp_rdata, 0);
        chk("post_rst_err_addr", err_addr, 0);
        $display("reset applied at cycle %0d", cyc);
    endtask

    initial begin
        int rb;
        logic [2:0]  rf;
        logic [11:0] ra;
        for (int i = 0; i < 4096; i++) begin
            mem_bytes[i] = 8'd0;
            ref_mem[i]   = 8'd0;
        end
        rd_reg = 32'd0;
        resp_total = 0; stall_total = 0; acc_cyc = 0; resp_cyc = 0;
        resp_data = 32'd0; last_acc = 1'b0;
        req_valid = 1'b0; req_we = 1'b0; req_addr = 32'd0; req_wdata = 32'd0; req_funct3 = 3'd0;
        @(negedge clk);
        do_reset();
        idle(1);

        // sw then lw: load waits for the drain, 2-cycle latency
        req(1'b1, 32'h0000_0100, 32'hDEAD_BEEF, F3_W);
        req(1'b0, 32'h0000_0100, 32'h0, F3_W);
        idle(3);
        chk("lw_latency", 32'(resp_cyc - acc_cyc), 2);
        chk("lw_data", resp_data, 32'hDEAD_BEEF);

        // fill the buffer while a load blocks the drain
        stall_total = 0;
        req(1'b0, 32'h0000_0300, 32'h0, F3_W);
        for (int i = 1; i <= 5; i++) req(1'b1, 32'h0000_0300, 32'(i), F3_W);
        chk("full_stall_seen", 32'(stall_total != 0), 1);
        idle(4);
        chk("fill_drained", 32'(sb_count), 0);
        req(1'b0, 32'h0000_0300, 32'h0, F3_W);
        idle(3);
        chk("fill_order_last", resp_data, 32'd5);

        // byte store, signed and unsigned reload
        req(1'b1, 32'h0000_0203, 32'h0000_0080, F3_B);
        req(1'b0, 32'h0000_0203, 32'h0, F3_B);
        idle(3);
        chk("lb_sext", resp_data, 32'hFFFF_FF80);
        req(1'b0, 32'h0000_0203, 32'h0, F3_BU);
        idle(3);
        chk("lbu_zext", resp_data, 32'h0000_0080);

        // faults
        rb = resp_total;
        req(1'b0, 32'h0000_0102, 32'h0, F3_W);
        chk("err_lw_valid", 32'(err_valid), 1);
        chk("err_lw_addr", err_addr, 32'h0000_0102);
        req(1'b1, 32'h0000_0101, 32'h1234, F3_H);
        chk("err_sh_valid", 32'(err_valid), 1);
        chk("err_sh_addr", err_addr, 32'h0000_0101);
        req(1'b0, 32'h0000_0040, 32'h0, 3'b011);
        chk("err_f3_valid", 32'(err_valid), 1);
        chk("err_f3_addr", err_addr, 32'h0000_0040);
        idle(3);
        chk("err_no_resp", 32'(resp_total - rb), 0);
        chk("err_addr_sticky", err_addr, 32'h0000_0040);

        // reset with a load in LD_ISSUE
        rb = resp_total;
        req(1'b0, 32'h0000_0200, 32'h0, F3_W);
        do_reset();
        idle(3);
        chk("rst_drop_load", 32'(resp_total - rb), 0);

        // reset with two stores pending
        req(1'b0, 32'h0000_0400, 32'h0, F3_W);
        req(1'b1, 32'h0000_0400, 32'h1111_1111, F3_W);
        req(1'b1, 32'h0000_0404, 32'h2222_2222, F3_W);
        chk("two_pending", 32'(sb_count), 2);
        do_reset();
        req(1'b0, 32'h0000_0400, 32'h0, F3_W);
        idle(3);
        chk("rst_discard_store", resp_data, 32'h0);

        // push while the head drains
        req(1'b1, 32'h0000_0500, 32'hAAAA_0001, F3_W);
        req(1'b1, 32'h0000_0504, 32'hBBBB_0002, F3_W);
        chk("pushpop_count", 32'(sb_count), 1);
        idle(2);
        req(1'b0, 32'h0000_0500, 32'h0, F3_W);
        idle(3);
        chk("pushpop_first", resp_data, 32'hAAAA_0001);
        req(1'b0, 32'h0000_0504, 32'h0, F3_W);
        idle(3);
        chk("pushpop_second", resp_data, 32'hBBBB_0002);

        // random traffic
        for (int k = 0; k < 400; k++) begin
            req_valid = ($urandom_range(0, 3) != 0);
            req_we    = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0) rf = 3'($urandom_range(0, 7));
            else if (req_we) rf = 3'($urandom_range(0, 2));
            else begin
                case ($urandom_range(0, 4))
                    0:       rf = F3_B;
                    1:       rf = F3_H;
                    2:       rf = F3_W;
                    3:       rf = F3_BU;
                    default: rf = F3_HU;
                endcase
            end
            ra = 12'($urandom_range(0, 63));
            if ($urandom_range(0, 7) != 0) begin
                if (rf[1:0] == 2'b01) ra[0] = 1'b0;
                if (rf[1:0] == 2'b10) ra[1:0] = 2'b00;
            end
            req_addr   = {20'($urandom), ra};
            req_wdata  = $urandom;
            req_funct3 = rf;
            tick();
            if (last_acc)
                $display("rand cycle %0d: we=%0d addr=%h f3=%0d accepted", cyc, req_we, req_addr, rf);
        end
        idle(6);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
